// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one write port,
// optional writeback bypass and a per-register busy scoreboard for decode hazards.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    output logic [DATA_WIDTH-1:0] rout1,
    output logic [DATA_WIDTH-1:0] rout2,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  waw
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic                  wr_ok;
    logic                  iss_ok;
    logic                  zr1;
    logic                  zr2;
    logic                  byp1;
    logic                  byp2;

    assign wr_ok  = write_en && !(ZERO_REG != 0 && a3 == '0);
    assign iss_ok = issue_en && !(ZERO_REG != 0 && issue_rd == '0);

    // The issue is applied after the write clear so that a new producer wins over a retiring one.
    always_comb begin
        busy_next = busy;
        if (wr_ok)
            busy_next[a3] = 1'b0;
        if (iss_ok)
            busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok)
                regs[a3] <= din;
            busy <= busy_next;
        end
    end

    assign zr1  = ZERO_REG != 0 && a1 == '0;
    assign zr2  = ZERO_REG != 0 && a2 == '0;
    assign byp1 = BYPASS != 0 && write_en && !rst && a3 == a1;
    assign byp2 = BYPASS != 0 && write_en && !rst && a3 == a2;

    assign rout1 = zr1 ? '0 : byp1 ? din : regs[a1];
    assign rout2 = zr2 ? '0 : byp2 ? din : regs[a2];
    assign busy1 = !zr1 && !byp1 && busy[a1];
    assign busy2 = !zr2 && !byp2 && busy[a2];

    assign waw = issue_en && !rst && !(ZERO_REG != 0 && issue_rd == '0)
                 && busy[issue_rd] && !(write_en && a3 == issue_rd);
endmodule
